// File: rtl/pipelined_shift_unit.sv
// Two-stage 32-bit barrel shifter (SLL/SRA/SRL/ROTR) with valid/ready flow control.
// Stage 1 resolves the 16/8-bit steps, stage 2 the 4/2/1-bit steps; results emerge in FIFO order.
module pipelined_shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_SRL  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  // One fixed-size step of the barrel. k is always a nonzero power of two below WIDTH.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       op,
                                                  input int unsigned      k);
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      OP_SLL:  r = d << k;
      OP_SRA:  r = $unsigned($signed(d) >>> k);
      OP_SRL:  r = d >> k;
      OP_ROTR: r = (d >> k) | (d << (WIDTH - k));
      default: r = d;
    endcase
    return r;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [2:0]       s1_shamt_lo_q, s1_shamt_lo_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;

  logic s1_adv;
  logic s2_adv;

  logic [WIDTH-1:0] s1_chain [0:2];
  logic [WIDTH-1:0] s2_chain [0:3];

  // Stage 1: 16-bit step then 8-bit step, selected by shamt[4] and shamt[3].
  assign s1_chain[0] = in_data;
  for (genvar gi = 0; gi < 2; gi++) begin : g_stage1
    localparam int unsigned K = 16 >> gi;
    assign s1_chain[gi+1] = in_shamt[4-gi] ? shift_step(s1_chain[gi], in_op, K)
                                           : s1_chain[gi];
  end

  // Stage 2: 4, 2 and 1-bit steps driven by the low shift bits carried in s1.
  assign s2_chain[0] = s1_data_q;
  for (genvar gi = 0; gi < 3; gi++) begin : g_stage2
    localparam int unsigned K = 4 >> gi;
    assign s2_chain[gi+1] = s1_shamt_lo_q[2-gi] ? shift_step(s2_chain[gi], s1_op_q, K)
                                                : s2_chain[gi];
  end

  // No skid buffer: acceptance depends combinationally on the downstream ready.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_data_d     = s1_data_q;
    s1_shamt_lo_d = s1_shamt_lo_q;
    s1_op_d       = s1_op_q;
    s2_valid_d    = s2_valid_q;
    s2_data_d     = s2_data_q;
    if (s1_adv) begin
      s1_valid_d    = in_valid && in_ready;
      s1_data_d     = s1_chain[2];
      s1_shamt_lo_d = in_shamt[2:0];
      s1_op_d       = in_op;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s2_chain[3];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_shamt_lo_q <= '0;
      s1_op_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_data_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      s1_shamt_lo_q <= s1_shamt_lo_d;
      s1_op_q       <= s1_op_d;
      s2_valid_q    <= s2_valid_d;
      s2_data_q     <= s2_data_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Self-checking bench for pipelined_shift_unit: vector table, scoreboard queue,
// plus hand-written backpressure and mid-flight reset sequences.
module tb_pipelined_shift_unit;

  localparam logic [1:0] SLL = 2'b00, SRA = 2'b01, SRL = 2'b10, ROTR = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  pipelined_shift_unit #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          acc_cyc;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] cur_exp  = '0;
  bit          chk_lat  = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push at input transfer, pop and compare at output transfer.
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      if (in_valid && in_ready) begin
        sb_q.push_back('{exp: cur_exp, acc_cyc: cyc});
        $display("IN  cyc=%0d data=0x%08h shamt=%0d op=%0d", cyc, in_data, in_shamt, in_op);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          $display("OUT cyc=%0d data=0x%08h exp=0x%08h", cyc, out_data, e.exp);
          check("out_data", out_data, e.exp);
          if (chk_lat) check("latency", cyc - e.acc_cyc, 32'd2);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                      input logic [31:0] e);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_op = o; cur_exp = e;
    do begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs[18];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h80000000, 5'd16, SRA,  32'hFFFF8000};
    vecs[1]  = '{32'h80000000, 5'd16, SRL,  32'h00008000};
    vecs[2]  = '{32'h00000001, 5'd31, SLL,  32'h80000000};
    vecs[3]  = '{32'h7FFFFFFF, 5'd31, SRA,  32'h00000000};
    vecs[4]  = '{32'h80000000, 5'd31, SRA,  32'hFFFFFFFF};
    vecs[5]  = '{32'h12345678, 5'd8,  ROTR, 32'h78123456};
    vecs[6]  = '{32'h12345678, 5'd4,  ROTR, 32'h81234567};
    vecs[7]  = '{32'h12345678, 5'd0,  ROTR, 32'h12345678};
    vecs[8]  = '{32'h12345678, 5'd31, ROTR, 32'h2468ACF0};
    vecs[9]  = '{32'h12345678, 5'd0,  SLL,  32'h12345678};
    vecs[10] = '{32'h80000001, 5'd0,  SRA,  32'h80000001};
    vecs[11] = '{32'hF0000000, 5'd4,  SRL,  32'h0F000000};
    vecs[12] = '{32'hF0000000, 5'd4,  SRA,  32'hFF000000};
    vecs[13] = '{32'hDEADBEEF, 5'd8,  SLL,  32'hADBEEF00};
    vecs[14] = '{32'h40000000, 5'd30, SRA,  32'h00000001};
    vecs[15] = '{32'hFFFFFFFF, 5'd31, SRL,  32'h00000001};
    vecs[16] = '{32'hABCDEF01, 5'd16, ROTR, 32'hEF01ABCD};
    vecs[17] = '{32'h80000000, 5'd5,  SRA,  32'hFC000000};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;

    // Table vectors, issued back to back with the consumer always ready.
    for (int i = 0; i < 18; i++) send(vecs[i].data, vecs[i].shamt, vecs[i].op, vecs[i].exp);
    drain();

    // ROTR stream with no bubbles: latency 2 on every item implies consecutive results.
    for (int i = 1; i <= 5; i++) send(32'h00000001, 5'(i), ROTR, 32'h80000000 >> (i - 1));
    drain();

    // Backpressure: two accepted, third stalls, output held stable.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    send(32'h00000010, 5'd4, SRL, 32'h00000001);
    send(32'h00000001, 5'd3, SLL, 32'h00000008);
    in_valid = 1'b1; in_data = 32'h80000000; in_shamt = 5'd1; in_op = SRA; cur_exp = 32'hC0000000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data_stable", out_data, 32'h00000001);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    drain();
    chk_lat = 1'b1;

    // Reset with two requests in flight: nothing stale may emerge afterwards.
    send(32'h0000FFFF, 5'd8, SLL, 32'h00FFFF00);
    send(32'h0000FFFF, 5'd8, SRL, 32'h000000FF);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sb_q.delete();
    @(negedge clock);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_out_data", out_data, 32'h0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) begin
      @(posedge clock); #1;
      check("rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    send(32'h87654321, 5'd12, ROTR, 32'h32187654);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
